// File: rtl/parallel_to_serial_pkg.sv
// Shared types and helpers for the parallel_to_serial transmitter.
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  // Bit counter width needed to count 0 .. w-1.
  function automatic int unsigned p2s_cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/p2s_hold_buffer.sv
// One-entry valid/data holding register with load and clear; load wins.
module p2s_hold_buffer
  import p2s_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [width-1:0] load_data,
  output logic             valid,
  output logic [width-1:0] data
);

  // Entry register: capture on load, drop on clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts a width-bit word on a valid/ready handshake and
// emits it LSB first, one bit per accepted serial beat.
// Build option: define PARALLEL_TO_SERIAL_PREFETCH_EN to add a one-word
// prefetch buffer for zero-bubble back-to-back streaming.
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  input  logic             serial_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last
);

  localparam int unsigned CW = p2s_cnt_width(width);
  localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

  if (width < 2) begin : g_bad_width
    $error("parallel_to_serial: width must be 2 or more");
  end

  p2s_state_e       state_q, state_d;
  logic [width-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             word_xfer;
  logic             bit_xfer;
  logic             at_last;

`ifdef PARALLEL_TO_SERIAL_PREFETCH_EN
  logic             buf_valid;
  logic [width-1:0] buf_data;
  logic             buf_load;
  logic             buf_clear;

  p2s_hold_buffer #(.width(width)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_data (parallel_data),
    .valid     (buf_valid),
    .data      (buf_data)
  );

  assign parallel_ready = !buf_valid;
`else
  assign parallel_ready = (state_q == P2S_IDLE);
`endif

  assign word_xfer    = parallel_valid && parallel_ready;
  assign bit_xfer     = serial_valid && serial_ready;
  assign at_last      = (cnt_q == LAST_CNT);
  assign serial_valid = (state_q == P2S_SHIFT);
  assign serial_data  = (state_q == P2S_SHIFT) ? shift_q[0] : 1'b0;
  assign serial_last  = (state_q == P2S_SHIFT) && at_last;

  // State, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= P2S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load in IDLE, shift on each accepted beat, reload or stop at the last bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PARALLEL_TO_SERIAL_PREFETCH_EN
    buf_load  = 1'b0;
    buf_clear = 1'b0;
`endif
    unique case (state_q)
      P2S_IDLE: begin
        if (word_xfer) begin
          shift_d = parallel_data;
          cnt_d   = '0;
          state_d = P2S_SHIFT;
        end
      end
      P2S_SHIFT: begin
        if (bit_xfer && at_last) begin
`ifdef PARALLEL_TO_SERIAL_PREFETCH_EN
          // A word landing on the last-bit edge with the buffer empty goes
          // straight into the shift register rather than being stranded.
          if (buf_valid) begin
            shift_d   = buf_data;
            cnt_d     = '0;
            buf_clear = 1'b1;
          end else if (word_xfer) begin
            shift_d = parallel_data;
            cnt_d   = '0;
          end else begin
            state_d = P2S_IDLE;
          end
`else
          state_d = P2S_IDLE;
`endif
        end else begin
`ifdef PARALLEL_TO_SERIAL_PREFETCH_EN
          buf_load = word_xfer;
`endif
          if (bit_xfer) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = P2S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial (width 8), valid for both builds.
module tb_parallel_to_serial;

  localparam int W = 8;
`ifdef PARALLEL_TO_SERIAL_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         pv;
  logic         pr;
  logic [W-1:0] pd;
  logic         sr;
  logic         sv;
  logic         sd;
  logic         sl;

  always #5 clk = ~clk;

  parallel_to_serial #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .parallel_valid (pv),
    .parallel_ready (pr),
    .parallel_data  (pd),
    .serial_ready   (sr),
    .serial_valid   (sv),
    .serial_data    (sd),
    .serial_last    (sl)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one word at full rate and check all its bits, then the return to idle.
  task automatic expect_word(input string name, input logic [W-1:0] word);
    pv = 1'b1; pd = word; sr = 1'b1;
    cycle();
    pv = 1'b0;
    for (int i = 0; i < W; i++) begin
      check({name, "_valid"}, int'(sv), 1);
      check({name, "_bit"},   int'(sd), int'(word[i]));
      check({name, "_last"},  int'(sl), (i == W - 1) ? 1 : 0);
      cycle();
    end
    check({name, "_idle"}, int'(sv), 0);
  endtask

  typedef struct {
    logic         rst;
    logic         pv;
    logic [W-1:0] pd;
    logic         sr;
    logic         sv;
    logic         sd;
    logic         sl;
    logic         pr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [W-1:0] words[3];
    logic [W-1:0] exp_bits3;
    logic         got[$];
    logic         gotl[$];
    logic [W-1:0] rx_q[$];
    logic [W-1:0] rx;
    logic         sb_bit[$];
    logic         sb_last[$];
    logic [2:0]   prev;
    logic [3:0]   pat;
    logic         xb, acc;
    int           rx_cnt, sent, accepted, gaps, out_words, exp_pr;
    bit           started, done;

    // Reset, idle, then one A5 word at full rate.
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, PF};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, PF};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, PF};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, PF};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, PF};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, PF};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, PF};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, PF};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; pv = 1'b0; pd = '0; sr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; pv = tbl[i].pv; pd = tbl[i].pd; sr = tbl[i].sr;
      cycle();
      check($sformatf("vec%0d_valid", i), int'(sv), int'(tbl[i].sv));
      check($sformatf("vec%0d_data",  i), int'(sd), int'(tbl[i].sd));
      check($sformatf("vec%0d_last",  i), int'(sl), int'(tbl[i].sl));
      check($sformatf("vec%0d_ready", i), int'(pr), int'(tbl[i].pr));
    end

    // Backpressure: 3C with serial_ready cycling 1,0,0,1.
    pat = 4'b1001;
    pv = 1'b1; pd = 8'h3C; sr = 1'b0;
    cycle();
    pv = 1'b0;
    got.delete();
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      sr   = pat[k % 4];
      prev = {sv, sd, sl};
      if (sv && sr) begin
        got.push_back(sd);
        gotl.push_back(sl);
      end
      cycle();
      if (!sr) check("bp_hold", int'({sv, sd, sl}), int'(prev));
      if (got.size() == W) done = 1'b1;
    end
    check("bp_count", got.size(), W);
    exp_bits3 = 8'h3C;
    for (int i = 0; i < W && i < got.size(); i++) begin
      check($sformatf("bp_bit%0d", i), int'(got[i]), int'(exp_bits3[i]));
      check($sformatf("bp_last%0d", i), int'(gotl[i]), (i == W - 1) ? 1 : 0);
    end
    sr = 1'b1;
    cycle();
    check("bp_idle", int'(sv), 0);

    // Back-to-back FF then 00 with parallel_valid held.
    got.delete(); gotl.delete();
    pv = 1'b1; pd = 8'hFF; sr = 1'b1;
    accepted = 0; gaps = 0; started = 1'b0;
    for (int k = 0; k < 60 && got.size() < 2 * W; k++) begin
      if (sv) started = 1'b1;
      else if (started) gaps++;
      xb  = sv && sr;
      acc = pv && pr;
      if (xb) begin
        got.push_back(sd);
        gotl.push_back(sl);
      end
      cycle();
      if (acc) begin
        accepted++;
        if (accepted == 1) pd = 8'h00;
        else pv = 1'b0;
      end
    end
    pv = 1'b0;
    check("b2b_words", accepted, 2);
    check("b2b_bits", got.size(), 2 * W);
    check("b2b_gaps", gaps, PF ? 0 : 1);
    for (int i = 0; i < 2 * W && i < got.size(); i++) begin
      check($sformatf("b2b_bit%0d", i), int'(got[i]), (i < W) ? 1 : 0);
      check($sformatf("b2b_last%0d", i), int'(gotl[i]), (i % W == W - 1) ? 1 : 0);
    end
    cycle();
    check("b2b_idle", int'(sv), 0);

    // Reset mid-word (with a second word offered so a prefetch build buffers it).
    pv = 1'b1; pd = 8'h81; sr = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    pv = 1'b0; rst = 1'b0;
    cycle();
    check("rst_mid_valid", int'(sv), 0);
    check("rst_mid_data",  int'(sd), 0);
    check("rst_mid_last",  int'(sl), 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rst_mid_discard", int'(sv), 0);
      check("rst_mid_ready", int'(pr), 1);
    end
    expect_word("post_rst_7E", 8'h7E);

    // Loopback into a behavioural receiver with random serial backpressure.
    words[0] = 8'hA5; words[1] = 8'h5A; words[2] = 8'hC3;
    sent = 0; rx_cnt = 0; rx = '0; rx_q.delete();
    pv = 1'b1; pd = words[0];
    for (int k = 0; k < 400 && rx_q.size() < 3; k++) begin
      sr  = ($urandom_range(0, 3) != 0);
      xb  = sv && sr;
      acc = pv && pr;
      if (xb) begin
        check("loop_last", int'(sl), (rx_cnt == W - 1) ? 1 : 0);
        rx[rx_cnt] = sd;
        rx_cnt++;
        if (rx_cnt == W) begin
          rx_q.push_back(rx);
          rx_cnt = 0;
        end
      end
      cycle();
      if (acc) begin
        sent++;
        if (sent < 3) pd = words[sent];
        else pv = 1'b0;
      end
    end
    pv = 1'b0;
    check("loop_count", rx_q.size(), 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      check($sformatf("loop_word%0d", i), int'(rx_q[i]), int'(words[i]));

    // Random traffic against a queue-of-bits reference model.
    rst = 1'b0; sr = 1'b0;
    cycle();
    rst = 1'b1;
    sb_bit.delete(); sb_last.delete();
    for (int k = 0; k < 1500; k++) begin
      out_words = (sb_bit.size() + W - 1) / W;
      exp_pr    = PF ? ((out_words < 2) ? 1 : 0) : ((out_words == 0) ? 1 : 0);
      check("rnd_ready", int'(pr), exp_pr);
      check("rnd_valid", int'(sv), (sb_bit.size() > 0) ? 1 : 0);
      if (sb_bit.size() > 0) begin
        check("rnd_data", int'(sd), int'(sb_bit[0]));
        check("rnd_last", int'(sl), int'(sb_last[0]));
      end else begin
        check("rnd_data_idle", int'(sd), 0);
      end
      pv  = ($urandom_range(0, 2) != 0);
      pd  = W'($urandom());
      sr  = ($urandom_range(0, 4) != 0);
      xb  = sv && sr;
      acc = pv && pr;
      cycle();
      if (xb && sb_bit.size() > 0) begin
        void'(sb_bit.pop_front());
        void'(sb_last.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          sb_bit.push_back(pd[i]);
          sb_last.push_back(i == W - 1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side counterpart of the serial_to_parallel receiver. Accepts a `width`-bit word over a valid/ready handshake and emits it one bit per accepted serial beat, LSB first. The bit order matches the receiver, so a direct loopback reproduces the original word. An optional one-word prefetch buffer allows back-to-back words with no idle cycles.

## Interface
Parameters:
- `width`, default 8: bits per parallel word; legal range is 2 or more (elaboration error otherwise).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0), sampled on the rising edge of `clk`.
- `parallel_valid`  in  1  upstream word available.
- `parallel_ready`  out  1  block can take a word this cycle.
- `parallel_data`  in  `width`  word to serialise; bit 0 is sent first.
- `serial_ready`  in  1  downstream accepts the current bit.
- `serial_valid`  out  1  `serial_data` holds a valid bit.
- `serial_data`  out  1  current bit; 0 whenever `serial_valid` is 0.
- `serial_last`  out  1  high with bit `width-1` of each word.

## Operation
- **Word transfer:** occurs on a rising edge where `parallel_valid && parallel_ready`; `parallel_data` is captured at that edge.
- **Bit transfer:** occurs on a rising edge where `serial_valid && serial_ready`. The shift register moves right by one and the bit counter increments.
- **FSM, IDLE:** `serial_valid=0`. A word transfer loads the shift register, clears the counter and moves to SHIFT.
- **FSM, SHIFT:** `serial_valid=1` and `serial_data` = shift register bit 0. On the bit transfer at counter = `width-1`:
  - if a buffered word exists, load it and stay in SHIFT;
  - otherwise go to IDLE.
- **Bit counter:** `$clog2(width)` bits. It wraps to 0 only via reload and never counts past `width-1`.
- **Backpressure:** while `serial_ready=0`, `serial_valid`, `serial_data` and `serial_last` hold unchanged.
- **Output derivation:** `parallel_ready` is driven from registers only, with no combinational path from `parallel_valid`. `serial_last` = SHIFT && counter==`width-1`.
- **Reset values:** on reset (`rst=0` at an edge) the block enters IDLE and clears the shift register, counter and prefetch buffer. `serial_valid=0`, `serial_data=0`, `serial_last=0`. `parallel_ready` = 1 once reset is released.
- **Reset mid-word:** the word in flight and any buffered word are discarded without completing. Transmission resumes only with a new word transfer.

## Timing
- **Latency:** bit 0 appears the cycle after the word-transfer edge.
- **Full rate:** with `serial_ready` held high, the word occupies exactly `width` consecutive cycles.
- **Without prefetch:** `parallel_ready` = IDLE. There is exactly one idle serial cycle between consecutive words (throughput `width`/(`width`+1)).
- **With prefetch:** `parallel_ready` = !buffer_full, and the last-bit transfer and a new word transfer may coincide on the same edge.
  - A word arriving in IDLE loads the shift register directly.
  - A word arriving in SHIFT fills the buffer.
  - Last-bit transfer with buffer full: the shift register reloads from the buffer and the buffer clears on the same edge, so there is no serial gap.
- **Simultaneous write while full:** not possible, because ready is low.

## Configuration
- Macro `PARALLEL_TO_SERIAL_PREFETCH_EN`.
- **Defined:** one-word prefetch buffer present, zero-bubble streaming, ready rule as above.
- **Undefined:** no buffer, `parallel_ready` high only in IDLE, one bubble per word.
- The port list is identical in both builds.

## Structure
- **Shared package `p2s_pkg`:**
  - state enum typedef `p2s_state_e` {P2S_IDLE, P2S_SHIFT};
  - a function returning the counter width for a given `width`.
- **Sub-module `p2s_hold_buffer`:** a one-entry valid/data register with load/clear. It is instantiated only under `PARALLEL_TO_SERIAL_PREFETCH_EN`.
- The FSM, shift register and counter stay in the top module.

## Test plan
All scenarios use `width=8`.
1. Reset then idle: `rst=0` for 2 cycles, then 1 → `serial_valid=0`, `serial_data=0`, `serial_last=0`, `parallel_ready=1`.
2. Single word: send 8'hA5 with `serial_ready=1` → bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after the transfer; `serial_last` only on the 8th; then IDLE.
3. Backpressure: send 8'h3C with `serial_ready` toggling 1,0,0,1,… → each bit is held while ready=0; the bit sequence is 0,0,1,1,1,1,0,0 and none is lost or duplicated.
4. Back-to-back: send 8'hFF then 8'h00 with `parallel_valid` held →
   - with macro: 16 contiguous valid cycles;
   - without macro: a single `serial_valid=0` cycle between the words.
5. Reset mid-word: assert `rst=0` after 3 bits of 8'h81 → the next cycle `serial_valid=0`; after release, 8'h7E serialises cleanly as 0,1,1,1,1,1,1,0.
6. Loopback: feed `serial_valid`/`serial_data` into serial_to_parallel; send 8'hA5, 8'h5A, 8'hC3 → the receiver reports 8'hA5, 8'h5A, 8'hC3 in order.
